// File: rtl/iir_out_buffer_if.sv
// Stream bus between the IIR filter output, the output buffer and its consumer.
// With IIR_OUT_BUF_DROP_CNT_EN defined the bus also carries the 8-bit drop counter.
interface iir_out_buffer_if #(
  parameter int DW = 14,
  parameter int AW = 3
);
  logic [DW-1:0] DIN;
  logic          VIN;
  logic          RDY;
  logic          CLR_OVF;
  logic [DW-1:0] DOUT;
  logic          VOUT;
  logic [AW:0]   LEVEL;
  logic          FULL;
  logic          OVF;
`ifdef IIR_OUT_BUF_DROP_CNT_EN
  logic [7:0]    DROP_CNT;

  modport master (output DIN, VIN, RDY, CLR_OVF,
                  input  DOUT, VOUT, LEVEL, FULL, OVF, DROP_CNT);
  modport slave  (input  DIN, VIN, RDY, CLR_OVF,
                  output DOUT, VOUT, LEVEL, FULL, OVF, DROP_CNT);
`else
  modport master (output DIN, VIN, RDY, CLR_OVF,
                  input  DOUT, VOUT, LEVEL, FULL, OVF);
  modport slave  (input  DIN, VIN, RDY, CLR_OVF,
                  output DOUT, VOUT, LEVEL, FULL, OVF);
`endif
endinterface

// File: rtl/iir_out_buffer.sv
// First-word-fall-through sample FIFO behind a non-stallable IIR filter, with sticky overflow.
// Optional drop counter (saturating at 255) enabled by IIR_OUT_BUF_DROP_CNT_EN.
module iir_out_buffer #(
  parameter int DW    = 14,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic           CLK,
  input  logic           RST,
  iir_out_buffer_if.slave bus
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          ovf;
  logic          vout, full, pop, push, drop;

  // Status is decoded only from the registered occupancy.
  assign vout = (level != '0);
  assign full = (level == FULL_LVL);
  assign pop  = vout & bus.RDY;
  assign push = bus.VIN & (~full | pop);
  assign drop = bus.VIN & full & ~pop;

  assign bus.VOUT  = vout;
  assign bus.FULL  = full;
  assign bus.LEVEL = level;
  assign bus.OVF   = ovf;
  assign bus.DOUT  = vout ? mem[rd_ptr] : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      // A drop in the clearing cycle wins, so no loss goes unreported.
      if (drop)             ovf <= 1'b1;
      else if (bus.CLR_OVF) ovf <= 1'b0;
    end
  end

  // Storage is not reset; DOUT is masked while empty instead.
  always_ff @(posedge CLK) begin
    if (!RST && push) mem[wr_ptr] <= bus.DIN;
  end

`ifdef IIR_OUT_BUF_DROP_CNT_EN
  logic [7:0] drop_cnt;
  assign bus.DROP_CNT = drop_cnt;

  always_ff @(posedge CLK) begin
    if (RST)                         drop_cnt <= '0;
    else if (bus.CLR_OVF)            drop_cnt <= {7'd0, drop};
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_iir_out_buffer.sv
// Scoreboard bench for iir_out_buffer: expected samples queued at push, compared at pop.
module tb_iir_out_buffer;
  localparam int DW = 14, DEPTH = 8, AW = 3;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  iir_out_buffer_if #(.DW(DW), .AW(AW)) bus ();

  iir_out_buffer #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] sbq [$];
  int m_lvl = 0;
  bit m_ovf = 0;
  int m_cnt = 0;

  // Pop monitor: inputs are stable at the falling edge before the popping edge.
  always @(negedge CLK) begin
    if (!RST && bus.VOUT && bus.RDY) begin
      n_chk++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: DOUT=%h popped, no sample expected", bus.DOUT);
      end else begin
        logic [DW-1:0] e;
        e = sbq.pop_front();
        if (bus.DOUT !== e) begin
          n_fail++;
          $display("FAIL pop_data: got %h expected %h", bus.DOUT, e);
        end
      end
    end
  end

  task automatic step(input logic vin, input logic [DW-1:0] din, input logic rdy, input logic clr);
    bit pop, push, drop;
    bus.VIN = vin; bus.DIN = din; bus.RDY = rdy; bus.CLR_OVF = clr;
    pop  = (m_lvl != 0) && rdy;
    push = vin && ((m_lvl != DEPTH) || pop);
    drop = vin && !push;
    if (push) sbq.push_back(din);
    m_lvl = m_lvl + int'(push) - int'(pop);
    if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
    if (clr) m_cnt = int'(drop); else if (drop && m_cnt < 255) m_cnt++;
    @(posedge CLK); #1;
    bus.VIN = 0; bus.DIN = '0; bus.RDY = 0; bus.CLR_OVF = 0;
  endtask

  task automatic do_rst(input logic vin, input logic rdy);
    RST = 1; bus.VIN = vin; bus.DIN = 14'h2AAA; bus.RDY = rdy; bus.CLR_OVF = 0;
    @(posedge CLK); #1;
    RST = 0; bus.VIN = 0; bus.DIN = '0; bus.RDY = 0;
    sbq.delete(); m_lvl = 0; m_ovf = 0; m_cnt = 0;
  endtask

  task automatic fill(input int n);
    for (int i = 1; i <= n; i++) step(1, DW'(i), 0, 0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 1, 0);
  endtask

  task automatic test_reset;
    do_rst(0, 0);
    n_chk++; if (bus.LEVEL !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", bus.LEVEL); end
    n_chk++; if (bus.VOUT !== 1'b0) begin n_fail++; $display("FAIL reset_vout: got %b expected 0", bus.VOUT); end
    n_chk++; if (bus.FULL !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus.FULL); end
    n_chk++; if (bus.OVF !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.OVF); end
    n_chk++; if (bus.DOUT !== '0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", bus.DOUT); end
`ifdef IIR_OUT_BUF_DROP_CNT_EN
    n_chk++; if (bus.DROP_CNT !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bus.DROP_CNT); end
`endif
  endtask

  task automatic test_single;
    step(1, 14'h1234, 0, 0);
    n_chk++; if (bus.VOUT !== 1'b1) begin n_fail++; $display("FAIL single_vout: got %b expected 1", bus.VOUT); end
    n_chk++; if (bus.DOUT !== 14'h1234) begin n_fail++; $display("FAIL single_dout: got %h expected 1234", bus.DOUT); end
    n_chk++; if (bus.LEVEL !== 4'd1) begin n_fail++; $display("FAIL single_level: got %0d expected 1", bus.LEVEL); end
    drain(1);
    n_chk++; if (bus.LEVEL !== 4'd0) begin n_fail++; $display("FAIL single_drain: got %0d expected 0", bus.LEVEL); end
  endtask

  task automatic test_rdy_empty;
    drain(3);
    step(1, 14'h0ABC, 0, 0);
    n_chk++; if (bus.DOUT !== 14'h0ABC || bus.LEVEL !== 4'd1) begin
      n_fail++; $display("FAIL rdy_empty: dout %h level %0d expected 0abc level 1", bus.DOUT, bus.LEVEL); end
    drain(1);
  endtask

  task automatic test_fill_drain;
    fill(8);
    n_chk++; if (bus.FULL !== 1'b1 || bus.LEVEL !== 4'd8) begin
      n_fail++; $display("FAIL fill_full: full %b level %0d expected 1/8", bus.FULL, bus.LEVEL); end
    drain(8);
    n_chk++; if (bus.LEVEL !== 4'd0 || bus.VOUT !== 1'b0) begin
      n_fail++; $display("FAIL fill_empty: level %0d vout %b expected 0/0", bus.LEVEL, bus.VOUT); end
  endtask

  task automatic test_overflow;
    fill(8);
    step(1, 14'h3FFF, 0, 0);
    n_chk++; if (bus.OVF !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", bus.OVF); end
    n_chk++; if (bus.LEVEL !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d expected 8", bus.LEVEL); end
    n_chk++; if (bus.DOUT !== 14'd1) begin n_fail++; $display("FAIL ovf_head: got %h expected 1", bus.DOUT); end
`ifdef IIR_OUT_BUF_DROP_CNT_EN
    n_chk++; if (bus.DROP_CNT !== 8'd1) begin n_fail++; $display("FAIL ovf_cnt: got %0d expected 1", bus.DROP_CNT); end
`endif
    step(0, '0, 0, 1);
    n_chk++; if (bus.OVF !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", bus.OVF); end
    drain(8);
  endtask

  task automatic test_full_pushpop;
    fill(8);
    step(1, 14'd9, 1, 0);
    n_chk++; if (bus.LEVEL !== 4'd8 || bus.OVF !== 1'b0) begin
      n_fail++; $display("FAIL full_pushpop: level %0d ovf %b expected 8/0", bus.LEVEL, bus.OVF); end
    drain(8);
    n_chk++; if (bus.VOUT !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_empty: vout %b expected 0", bus.VOUT); end
  endtask

  task automatic test_level1_pushpop;
    step(1, 14'h0011, 0, 0);
    step(1, 14'h0022, 1, 0);
    n_chk++; if (bus.LEVEL !== 4'd1 || bus.DOUT !== 14'h0022) begin
      n_fail++; $display("FAIL lvl1_pushpop: level %0d dout %h expected 1/0022", bus.LEVEL, bus.DOUT); end
    drain(1);
  endtask

  task automatic test_saturate;
    fill(8);
    for (int i = 0; i < 300; i++) step(1, 14'h3FFF, 0, 0);
    n_chk++; if (bus.OVF !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b expected 1", bus.OVF); end
`ifdef IIR_OUT_BUF_DROP_CNT_EN
    n_chk++; if (bus.DROP_CNT !== 8'd255) begin n_fail++; $display("FAIL sat_cnt: got %0d expected 255", bus.DROP_CNT); end
`endif
    step(0, '0, 0, 1);
    n_chk++; if (bus.OVF !== 1'b0) begin n_fail++; $display("FAIL sat_clr_ovf: got %b expected 0", bus.OVF); end
`ifdef IIR_OUT_BUF_DROP_CNT_EN
    n_chk++; if (bus.DROP_CNT !== 8'd0) begin n_fail++; $display("FAIL sat_clr_cnt: got %0d expected 0", bus.DROP_CNT); end
`endif
    step(1, 14'h0077, 0, 1);
    n_chk++; if (bus.OVF !== 1'b1) begin n_fail++; $display("FAIL clr_drop_ovf: got %b expected 1", bus.OVF); end
`ifdef IIR_OUT_BUF_DROP_CNT_EN
    n_chk++; if (bus.DROP_CNT !== 8'd1) begin n_fail++; $display("FAIL clr_drop_cnt: got %0d expected 1", bus.DROP_CNT); end
`endif
    step(0, '0, 0, 1);
    drain(8);
  endtask

  task automatic test_reset_mid;
    fill(5);
    n_chk++; if (bus.LEVEL !== 4'd5) begin n_fail++; $display("FAIL mid_level5: got %0d expected 5", bus.LEVEL); end
    do_rst(1, 1);
    n_chk++; if (bus.LEVEL !== 4'd0 || bus.VOUT !== 1'b0 || bus.DOUT !== '0) begin
      n_fail++; $display("FAIL mid_reset: level %0d vout %b dout %h expected 0/0/0", bus.LEVEL, bus.VOUT, bus.DOUT); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      n_chk++;
      if (bus.LEVEL !== 4'(m_lvl) || bus.FULL !== (m_lvl == DEPTH) || bus.VOUT !== (m_lvl != 0) || bus.OVF !== m_ovf) begin
        n_fail++;
        $display("FAIL b2b_state: level %0d full %b vout %b ovf %b expected level %0d ovf %b",
                 bus.LEVEL, bus.FULL, bus.VOUT, bus.OVF, m_lvl, m_ovf);
      end
`ifdef IIR_OUT_BUF_DROP_CNT_EN
      n_chk++; if (bus.DROP_CNT !== 8'(m_cnt)) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected %0d", bus.DROP_CNT, m_cnt); end
`endif
    end
    drain(DEPTH);
    n_chk++; if (sbq.size() != 0) begin n_fail++; $display("FAIL b2b_leftover: %0d samples never read, expected 0", sbq.size()); end
  endtask

  initial begin
    bus.VIN = 0; bus.DIN = '0; bus.RDY = 0; bus.CLR_OVF = 0;
    @(posedge CLK); #1;
    test_reset;
    test_single;
    test_rdy_empty;
    test_fill_drain;
    test_overflow;
    test_full_pushpop;
    test_level1_pushpop;
    test_saturate;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
